// File: rtl/mode_scheduler.sv
// mode_scheduler: top-level mode controller for the digital clock board.
// Time-shares the four 7-segment digits and the three setting buttons among
// the wall clock (mode 0), stopwatch (mode 1) and countdown timer (mode 2).
// Timer expiry pre-empts the display with a blinking alarm.
//
// Ports:
//   clk, reset (async, active-low)
//   mode_btn_n, set_sec_n, set_min_n, start_n : raw active-low buttons
//   timer_done                                : one-cycle expiry pulse
//   clk_seg, sw_seg, tmr_seg                  : requester digit buses {d3,d2,d1,d0}
//   mode, mode_en                             : current mode, one-hot enable
//   sec_btn_n, min_btn_n, start_btn_n         : debounced levels routed per mode
//   alarm_active                              : high while alarming
//   seg                                       : display bus
module mode_scheduler #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          BLINK_HALF      = 25000000,
  parameter int          ALARM_TOGGLES   = 20,
  parameter logic [6:0]  BLANK_SEG       = 7'b1111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_btn_n,
  input  logic        set_sec_n,
  input  logic        set_min_n,
  input  logic        start_n,
  input  logic        timer_done,
  input  logic [27:0] clk_seg,
  input  logic [27:0] sw_seg,
  input  logic [27:0] tmr_seg,
  output logic [1:0]  mode,
  output logic [2:0]  mode_en,
  output logic [2:0]  sec_btn_n,
  output logic [2:0]  min_btn_n,
  output logic [2:0]  start_btn_n,
  output logic        alarm_active,
  output logic [27:0] seg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam int TG_W = $clog2(ALARM_TOGGLES + 1);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_GAP    = 2'd1;
  localparam logic [1:0] ST_ALARM  = 2'd2;

  // Button index: 0 mode, 1 seconds, 2 minutes, 3 start.
  logic [3:0] raw_n;
  logic [3:0] deb_lvl;
  logic [3:0] press;

  assign raw_n = {start_n, set_min_n, set_sec_n, mode_btn_n};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic            s1_q, s2_q, lvl_q, lvl_d, prs_q;
      logic [DB_W-1:0] cnt_q, cnt_d;

      // Count consecutive cycles the synchronized level disagrees with the
      // accepted level; accept it on the last one. Any agreement restarts.
      always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl_d = s2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_q  <= 1'b1;
          s2_q  <= 1'b1;
          lvl_q <= 1'b1;
          prs_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          s1_q  <= raw_n[gi];
          s2_q  <= s1_q;
          lvl_q <= lvl_d;
          cnt_q <= cnt_d;
          prs_q <= lvl_q & ~lvl_d;
        end
      end

      assign deb_lvl[gi] = lvl_q;
      assign press[gi]   = prs_q;
    end
  endgenerate

  logic [1:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic            phase_q, phase_d;      // 1 = digits visible
  logic [BL_W-1:0] blink_q, blink_d;
  logic [TG_W-1:0] tog_q, tog_d;
  logic [2:0]      mode_en_q, mode_en_d;
  logic            alarm_q, alarm_d;
  logic [2:0]      supp_q, supp_d;        // sec/min/start presses swallowed by the alarm

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    blink_d = blink_q;
    tog_d   = tog_q;

    if (timer_done) begin
      // Expiry beats everything, including a same-cycle mode press.
      state_d = ST_ALARM;
      mode_d  = 2'd2;
      phase_d = 1'b1;
      blink_d = '0;
      tog_d   = '0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (press[0]) state_d = ST_GAP;
        end
        ST_GAP: begin
          state_d = ST_NORMAL;
          mode_d  = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
        end
        ST_ALARM: begin
          if (|press) begin
            state_d = ST_NORMAL;
          end else if (blink_q == BL_W'(BLINK_HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
            if (tog_q != TG_W'(ALARM_TOGGLES)) tog_d = tog_q + 1'b1;
            if (tog_q == TG_W'(ALARM_TOGGLES - 1)) state_d = ST_NORMAL;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_NORMAL;
          mode_d  = 2'd0;
        end
      endcase
    end

    if (state_d != ST_ALARM) begin
      phase_d = 1'b1;
      blink_d = '0;
      tog_d   = '0;
    end

    case (state_d)
      ST_ALARM: mode_en_d = 3'b100;
      ST_GAP:   mode_en_d = 3'b000;
      default:  mode_en_d = 3'b001 << mode_d;
    endcase
    alarm_d = (state_d == ST_ALARM);

    // A press that dismisses the alarm must not leak to the timer once we
    // are back in NORMAL; hold it off until the button is released.
    for (int i = 0; i < 3; i++) begin
      supp_d[i] = supp_q[i];
      if (!timer_done && state_q == ST_ALARM && press[i+1]) begin
        supp_d[i] = 1'b1;
      end else if (deb_lvl[i+1]) begin
        supp_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_NORMAL;
      mode_q    <= 2'd0;
      phase_q   <= 1'b1;
      blink_q   <= '0;
      tog_q     <= '0;
      mode_en_q <= 3'b001;
      alarm_q   <= 1'b0;
      supp_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      blink_q   <= blink_d;
      tog_q     <= tog_d;
      mode_en_q <= mode_en_d;
      alarm_q   <= alarm_d;
      supp_q    <= supp_d;
    end
  end

  // Routing uses only registered selects, so outputs settle right after the edge.
  always_comb begin
    sec_btn_n   = 3'b111;
    min_btn_n   = 3'b111;
    start_btn_n = 3'b111;
    if (state_q == ST_NORMAL) begin
      for (int i = 0; i < 3; i++) begin
        if (mode_q == 2'(i)) begin
          sec_btn_n[i]   = deb_lvl[1] | supp_q[0];
          min_btn_n[i]   = deb_lvl[2] | supp_q[1];
          start_btn_n[i] = deb_lvl[3] | supp_q[2];
        end
      end
    end
  end

  // Segment data passes straight through so digits are not delayed a cycle;
  // only the selection is registered.
  always_comb begin
    seg = {4{BLANK_SEG}};
    case (state_q)
      ST_NORMAL: begin
        case (mode_q)
          2'd0:    seg = clk_seg;
          2'd1:    seg = sw_seg;
          default: seg = tmr_seg;
        endcase
      end
      ST_ALARM: begin
        if (phase_q) seg = tmr_seg;
      end
      default: seg = {4{BLANK_SEG}};
    endcase
  end

  assign mode         = mode_q;
  assign mode_en      = mode_en_q;
  assign alarm_active = alarm_q;

endmodule

// File: tb/tb_mode_scheduler.sv
module tb_mode_scheduler;

  localparam int          DB  = 4;
  localparam int          BH  = 8;
  localparam int          AT  = 4;
  localparam logic [6:0]  BL  = 7'b1111111;
  localparam logic [27:0] BLANK4 = {4{BL}};
  localparam logic [27:0] CLK_V  = 28'h0123456;
  localparam logic [27:0] SW_V   = 28'hA5A5A5A;
  localparam logic [27:0] TMR_V  = 28'h5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode_btn_n = 1'b1, set_sec_n = 1'b1, set_min_n = 1'b1, start_n = 1'b1;
  logic        timer_done = 1'b0;
  logic [27:0] clk_seg = CLK_V, sw_seg = SW_V, tmr_seg = TMR_V;
  logic [1:0]  mode;
  logic [2:0]  mode_en, sec_btn_n, min_btn_n, start_btn_n;
  logic        alarm_active;
  logic [27:0] seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mode_scheduler #(
    .DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH), .ALARM_TOGGLES(AT), .BLANK_SEG(BL)
  ) dut (
    .clk(clk), .reset(reset),
    .mode_btn_n(mode_btn_n), .set_sec_n(set_sec_n), .set_min_n(set_min_n), .start_n(start_n),
    .timer_done(timer_done),
    .clk_seg(clk_seg), .sw_seg(sw_seg), .tmr_seg(tmr_seg),
    .mode(mode), .mode_en(mode_en),
    .sec_btn_n(sec_btn_n), .min_btn_n(min_btn_n), .start_btn_n(start_btn_n),
    .alarm_active(alarm_active), .seg(seg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: 0 mode, 1 sec, 2 min, 3 start.
  bit          m_s1 [4];
  bit          m_s2 [4];
  bit          m_deb [4];
  bit          m_press [4];
  bit          m_cons [4];
  bit [DB-1:0] m_win [4];      // last DB synchronized samples
  int          m_mode;
  bit          m_gap, m_alarm;
  int          m_age;          // edges since alarm entry

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_s1[b] = 1; m_s2[b] = 1; m_deb[b] = 1; m_press[b] = 0; m_cons[b] = 0;
      m_win[b] = '1;
    end
    m_mode = 0; m_gap = 0; m_alarm = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit [3:0] raw;
    bit       nd;
    raw = {start_n, set_min_n, set_sec_n, mode_btn_n};
    for (int b = 1; b < 4; b++) if (m_deb[b]) m_cons[b] = 0;
    if (timer_done) begin
      m_alarm = 1; m_gap = 0; m_mode = 2; m_age = 0;
    end else if (m_alarm) begin
      if (m_press[0] | m_press[1] | m_press[2] | m_press[3]) begin
        m_alarm = 0;
        for (int b = 1; b < 4; b++) if (m_press[b]) m_cons[b] = 1;
      end else begin
        m_age++;
        if (m_age == BH * AT) m_alarm = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_mode = (m_mode + 1) % 3;
    end else if (m_press[0]) begin
      m_gap = 1;
    end
    for (int b = 0; b < 4; b++) begin
      m_win[b] = {m_win[b][DB-2:0], m_s2[b]};
      nd = m_deb[b];
      if (m_win[b] == (m_deb[b] ? {DB{1'b0}} : {DB{1'b1}})) nd = ~m_deb[b];
      m_press[b] = m_deb[b] & ~nd;
      m_deb[b] = nd;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    logic [2:0]  e_en, e_sec, e_min, e_start;
    logic [27:0] e_seg;
    bit          normal;
    forever begin
      @(negedge clk);
      normal = !m_alarm && !m_gap;
      e_en = m_alarm ? 3'b100 : (m_gap ? 3'b000 : 3'(1 << m_mode));
      if (m_alarm) e_seg = (((m_age / BH) % 2) == 0) ? tmr_seg : BLANK4;
      else if (m_gap) e_seg = BLANK4;
      else e_seg = (m_mode == 0) ? clk_seg : ((m_mode == 1) ? sw_seg : tmr_seg);
      e_sec = 3'b111; e_min = 3'b111; e_start = 3'b111;
      for (int i = 0; i < 3; i++) begin
        if (normal && i == m_mode) begin
          e_sec[i]   = m_deb[1] | m_cons[1];
          e_min[i]   = m_deb[2] | m_cons[2];
          e_start[i] = m_deb[3] | m_cons[3];
        end
      end
      chk("mode", 28'(mode), 28'(m_mode));
      chk("mode_en", 28'(mode_en), 28'(e_en));
      chk("alarm_active", 28'(alarm_active), 28'(m_alarm));
      chk("seg", seg, e_seg);
      chk("sec_btn_n", 28'(sec_btn_n), 28'(e_sec));
      chk("min_btn_n", 28'(min_btn_n), 28'(e_min));
      chk("start_btn_n", 28'(start_btn_n), 28'(e_start));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_timer();
    timer_done = 1'b1;
    tick(1);
    timer_done = 1'b0;
  endtask

  // Hold mode button 10 cycles; press event after 6 edges, GAP at 7, new mode at 8.
  task automatic mode_press(input logic [1:0] nm, input logic [2:0] old_en,
                            input logic [2:0] new_en, input logic [27:0] nseg);
    mode_btn_n = 1'b0;
    tick(6);
    chk("lit_pre_gap_en", 28'(mode_en), 28'(old_en));
    tick(1);
    chk("lit_gap_en", 28'(mode_en), 28'(3'b000));
    chk("lit_gap_seg", seg, BLANK4);
    tick(1);
    chk("lit_new_mode", 28'(mode), 28'(nm));
    chk("lit_new_en", 28'(mode_en), 28'(new_en));
    chk("lit_new_seg", seg, nseg);
    tick(2);
    mode_btn_n = 1'b1;
    tick(8);
  endtask

  initial begin
    tick(3);
    chk("lit_rst_mode_en", 28'(mode_en), 28'(3'b001));
    chk("lit_rst_alarm", 28'(alarm_active), 28'(1'b0));
    chk("lit_rst_sec", 28'(sec_btn_n), 28'(3'b111));
    reset = 1'b1;
    tick(3);
    chk("lit_idle_mode", 28'(mode), 28'(2'd0));
    chk("lit_idle_seg", seg, CLK_V);
    chk("lit_idle_start", 28'(start_btn_n), 28'(3'b111));

    mode_press(2'd1, 3'b001, 3'b010, SW_V);

    // Glitch shorter than the debounce window.
    set_sec_n = 1'b0;
    tick(3);
    set_sec_n = 1'b1;
    tick(8);
    chk("lit_glitch_sec", 28'(sec_btn_n), 28'(3'b111));

    // Held seconds button in stopwatch mode.
    set_sec_n = 1'b0;
    tick(5);
    chk("lit_sec_before", 28'(sec_btn_n), 28'(3'b111));
    tick(1);
    chk("lit_sec_routed", 28'(sec_btn_n), 28'(3'b101));
    chk("lit_sec_min", 28'(min_btn_n), 28'(3'b111));
    tick(3);
    set_sec_n = 1'b1;
    tick(8);

    mode_press(2'd2, 3'b010, 3'b100, TMR_V);
    mode_press(2'd0, 3'b100, 3'b001, CLK_V);

    // Alarm from mode 0 runs to its timeout.
    pulse_timer();
    chk("lit_alarm_on", 28'(alarm_active), 28'(1'b1));
    chk("lit_alarm_mode", 28'(mode), 28'(2'd2));
    chk("lit_alarm_seg0", seg, TMR_V);
    tick(7);
    chk("lit_alarm_seg7", seg, TMR_V);
    tick(1);
    chk("lit_alarm_seg8", seg, BLANK4);
    tick(8);
    chk("lit_alarm_seg16", seg, TMR_V);
    tick(15);
    chk("lit_alarm_31", 28'(alarm_active), 28'(1'b1));
    tick(1);
    chk("lit_alarm_32", 28'(alarm_active), 28'(1'b0));
    chk("lit_alarm_exit_mode", 28'(mode), 28'(2'd2));
    chk("lit_alarm_exit_en", 28'(mode_en), 28'(3'b100));
    tick(3);

    // Start press dismisses the alarm and is consumed.
    pulse_timer();
    tick(2);
    start_n = 1'b0;
    tick(6);
    chk("lit_ack_still_on", 28'(alarm_active), 28'(1'b1));
    tick(1);
    chk("lit_ack_off", 28'(alarm_active), 28'(1'b0));
    chk("lit_ack_mode", 28'(mode), 28'(2'd2));
    chk("lit_ack_start", 28'(start_btn_n), 28'(3'b111));
    tick(3);
    chk("lit_ack_held", 28'(start_btn_n), 28'(3'b111));
    start_n = 1'b1;
    tick(8);

    // A fresh start press in timer mode is routed normally.
    start_n = 1'b0;
    tick(6);
    chk("lit_start_routed", 28'(start_btn_n), 28'(3'b011));
    start_n = 1'b1;
    tick(8);

    // Timer expiry in the same cycle as a mode press event.
    mode_btn_n = 1'b0;
    tick(6);
    pulse_timer();
    chk("lit_same_alarm", 28'(alarm_active), 28'(1'b1));
    chk("lit_same_en", 28'(mode_en), 28'(3'b100));
    tick(1);
    chk("lit_same_no_gap", 28'(mode_en), 28'(3'b100));
    chk("lit_same_mode", 28'(mode), 28'(2'd2));
    tick(2);
    mode_btn_n = 1'b1;
    tick(4);

    // Asynchronous reset mid-alarm.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("lit_async_alarm", 28'(alarm_active), 28'(1'b0));
    chk("lit_async_en", 28'(mode_en), 28'(3'b001));
    chk("lit_async_seg", seg, CLK_V);
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("lit_post_rst_mode", 28'(mode), 28'(2'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog cycle %0d: got timeout expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
